hazard_ctrl: RTL and testbench

//   Pipeline sequencing controller for the 5-stage core. Drives stall and flush

---
 rtl/hazard_ctrl_if.sv | 74 +++++++
 rtl/hazard_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//
// Purpose:
//   Bundles every signal exchanged between the pipeline datapath and the
//   hazard/sequencing controller. The datapath tells the controller what is
//   in D, E and M. The controller returns the stall/flush controls for the
//   pipe registers and the performance counters.
//
// Parameters:
//   AW     register-address width (Rs1D/Rs2D/RdE)
//   CNT_W  width of the performance counters
//
// Signals (direction given from the controller's point of view):
//   Rs1D, Rs2D   in   source registers of the instruction in D
//   RdE          in   destination register of the instruction in E
//   RegWriteE    in   instruction in E writes RdE
//   LME          in   instruction in E is a load
//   PCSrcE       in   branch resolved taken in E
//   MulStartE    in   instruction in E is a multi-cycle multiply
//   MemReqM      in   instruction in M accesses data memory
//   MemReadyM    in   data memory completes its access this cycle
//   StallF/D/E/M out  hold PC / F-D / D-E / E-M registers
//   FlushD/E     out  clear F-D / D-E registers
//   MulBusy      out  multiply sequencing in progress
//   StallCnt     out  cycles spent with StallF high
//   FlushCnt     out  taken-branch flushes
//
// Modports:
//   master  the pipeline side (drives hazard inputs, consumes controls)
//   slave   the controller side
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int AW    = 4,
    parameter int CNT_W = 16
);

    logic [AW-1:0]    Rs1D;
    logic [AW-1:0]    Rs2D;
    logic [AW-1:0]    RdE;
    logic             RegWriteE;
    logic             LME;
    logic             PCSrcE;
    logic             MulStartE;
    logic             MemReqM;
    logic             MemReadyM;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             MulBusy;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    // The pipeline produces the hazard information and obeys the controls.
    modport master (
        output Rs1D, Rs2D, RdE, RegWriteE, LME, PCSrcE, MulStartE,
               MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, MulBusy,
               StallCnt, FlushCnt
    );

    // The controller consumes the hazard information and produces the controls.
    modport slave (
        input  Rs1D, Rs2D, RdE, RegWriteE, LME, PCSrcE, MulStartE,
               MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, MulBusy,
               StallCnt, FlushCnt
    );

endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Pipeline sequencing controller for the 5-stage core. It sits beside the
//   pipe registers and decides, every cycle, which of them hold and which are
//   cleared. It handles these hazards:
//     - data-memory wait states (whole pipe holds, including E/M)
//     - multi-cycle multiply occupying E (front of pipe holds)
//     - taken branches resolved in E (wrong-path F-D and D-E are cleared)
//     - load-use dependencies (one bubble inserted into E)
//   Per-cycle priority is MEMWAIT > MUL > BRANCH > LOADUSE.
//
// Parameters:
//   AW       register-address width
//   MUL_LAT  cycles a multiply occupies E (>=1). A value of 1 disables
//            multiply sequencing entirely.
//   CNT_W    width of the performance counters
//
// Ports:
//   clk      rising-edge clock for all state
//   rst_n    synchronous active-low reset. While low, FlushD=FlushE=1 and
//            every other output is 0.
//   hz       hazard_ctrl_if.slave: hazard inputs in, stall/flush controls,
//            MulBusy and performance counters out
//
// Configuration:
//   HAZ_PERF_CNT_EN  when defined, StallCnt counts cycles with StallF=1 and
//                    FlushCnt counts taken-branch flush cycles. Both saturate
//                    at all-ones. When undefined, both outputs are tied to
//                    zero and no counter flops are built.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int AW      = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hz
);

    // The down-counter must be at least two bits wide and must be wide enough
    // to hold MUL_LAT-2, the value loaded on entry to MUL.
    localparam int MCW = (MUL_LAT > 4) ? $clog2(MUL_LAT) : 2;

    // Multiply sequencing only exists when a multiply takes more than one
    // cycle. With MUL_LAT=1 the E stage finishes the multiply like any other
    // instruction, so MulStartE is ignored.
    localparam bit MUL_EN = (MUL_LAT > 1);

    // On entry, the entry cycle is the first stall cycle. The counter then
    // covers the remaining MUL_LAT-2 stall cycles. The cycle on which it
    // reads zero is the final, non-stalled cycle of the multiply.
    localparam logic [MCW-1:0] MCNT_INIT = MCW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } stateT;

    stateT          state;
    stateT          stateNext;
    logic [MCW-1:0] mcnt;
    logic [MCW-1:0] mcntNext;

    logic [AW-1:0]  rs1D;
    logic [AW-1:0]  rs2D;
    logic [AW-1:0]  rdE;

    logic           memWait;
    logic           loadUse;

    logic           stallF;
    logic           stallD;
    logic           stallE;
    logic           stallM;
    logic           flushD;
    logic           flushE;
    logic           mulBusy;
    logic           branchFlush;

    assign rs1D = hz.Rs1D;
    assign rs2D = hz.Rs2D;
    assign rdE  = hz.RdE;

    // A memory wait holds the entire pipe, whatever else is happening.
    assign memWait = hz.MemReqM & ~hz.MemReadyM;

    // A load in E whose result is needed by the instruction in D cannot be
    // forwarded in time. Register 0 is hardwired, so it never creates a
    // dependency.
    assign loadUse = hz.LME & hz.RegWriteE & (rdE != '0)
                   & ((rdE == rs1D) | (rdE == rs2D));

    // State register for the multiply sequencer. Reset drops any multiply in
    // progress immediately, because the pipe is being flushed anyway.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            mcnt  <= '0;
        end else begin
            state <= stateNext;
            mcnt  <= mcntNext;
        end
    end

    // Next-state and output decode, in priority order. Each branch of the
    // if/else chain is one hazard class, so a higher-priority hazard
    // completely masks the ones below it for that cycle.
    //
    // MEMWAIT freezes the sequencer, so state and mcnt keep their values.
    // A taken branch that arrives during a memory wait is not latched. The
    // pipe is held, so PCSrcE stays asserted and is acted on in the first
    // cycle after the wait releases.
    //
    // While in MUL, the multiply owns E. Neither PCSrcE nor MulStartE can
    // refer to a different instruction, so both are ignored. In RUN, a taken
    // branch wins over a multiply start. A multiply on the wrong path must
    // never begin sequencing.
    always_comb begin
        stateNext   = state;
        mcntNext    = mcnt;
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        mulBusy     = 1'b0;
        branchFlush = 1'b0;

        if (!rst_n) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (memWait) begin
            stallF  = 1'b1;
            stallD  = 1'b1;
            stallE  = 1'b1;
            stallM  = 1'b1;
            mulBusy = (state == MUL);
        end else if (state == MUL) begin
            mulBusy = 1'b1;
            if (mcnt != '0) begin
                stallF   = 1'b1;
                stallD   = 1'b1;
                stallE   = 1'b1;
                mcntNext = mcnt - 1'b1;
            end else begin
                stateNext = RUN;
            end
        end else if (hz.PCSrcE) begin
            flushD      = 1'b1;
            flushE      = 1'b1;
            branchFlush = 1'b1;
        end else if (hz.MulStartE && MUL_EN) begin
            stallF    = 1'b1;
            stallD    = 1'b1;
            stallE    = 1'b1;
            mulBusy   = 1'b1;
            stateNext = MUL;
            mcntNext  = MCNT_INIT;
        end else if (loadUse) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    assign hz.StallF  = stallF;
    assign hz.StallD  = stallD;
    assign hz.StallE  = stallE;
    assign hz.StallM  = stallM;
    assign hz.FlushD  = flushD;
    assign hz.FlushE  = flushE;
    assign hz.MulBusy = mulBusy;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stallCntQ;
    logic [CNT_W-1:0] flushCntQ;

    // Performance counters. Each one sticks at all-ones rather than wrapping,
    // so a long run still reads as "at least this many" and never as a small
    // misleading number.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (stallF && !(&stallCntQ)) begin
                stallCntQ <= stallCntQ + 1'b1;
            end
            if (branchFlush && !(&flushCntQ)) begin
                flushCntQ <= flushCntQ + 1'b1;
            end
        end
    end

    // While reset is asserted, the counters read zero even before the first
    // reset edge has cleared the flops.
    assign hz.StallCnt = rst_n ? stallCntQ : '0;
    assign hz.FlushCnt = rst_n ? flushCntQ : '0;
`else
    assign hz.StallCnt = {CNT_W{1'b0}};
    assign hz.FlushCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Purpose:
//   Self-checking bench for hazard_ctrl with MUL_LAT=4, AW=4, CNT_W=16.
//   Directed vectors drive the hazard inputs. Each directed step carries a
//   hand-computed expectation. In parallel, a behavioural model compares
//   every output on every cycle. The model tracks "multiply cycles left"
//   rather than a state/counter pair.
//
// Control bundle bit order: {StallF,StallD,StallE,StallM,FlushD,FlushE,MulBusy}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int AW      = 4;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 16;

    logic clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    hazard_ctrl_if #(.AW(AW), .CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.AW(AW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    logic [6:0] dutCtrl;
    assign dutCtrl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                      hif.FlushD, hif.FlushE, hif.MulBusy};

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state. mulLeft is the number of cycles the current
    // multiply still occupies E, counting the present cycle.
    int mulLeft   = 0;
    int stallCntM = 0;
    int flushCntM = 0;

    // Compare process. Inputs change only just after a rising edge, so on the
    // falling edge they are stable. The model works out this cycle's outputs
    // directly from the hazard rules, checks the DUT, then advances its own
    // state as the coming rising edge will.
    always @(negedge clk) begin
        logic [6:0]       exp;
        logic [CNT_W-1:0] expSc;
        logic [CNT_W-1:0] expFc;
        logic             mw;
        logic             lu;
        logic             isBranch;

        mw = hif.MemReqM && !hif.MemReadyM;
        lu = hif.LME && hif.RegWriteE && (hif.RdE != 0) &&
             ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));
        isBranch = 1'b0;

        if (!rst_n)                               exp = 7'b0000110;
        else if (mw)                              exp = {6'b111100, (mulLeft > 0)};
        else if (mulLeft > 0)                     exp = (mulLeft > 1) ? 7'b1110001 : 7'b0000001;
        else if (hif.PCSrcE) begin                exp = 7'b0000110; isBranch = 1'b1; end
        else if (hif.MulStartE && MUL_LAT > 1)    exp = 7'b1110001;
        else if (lu)                              exp = 7'b1100010;
        else                                      exp = 7'b0000000;

`ifdef HAZ_PERF_CNT_EN
        expSc = rst_n ? CNT_W'(stallCntM) : '0;
        expFc = rst_n ? CNT_W'(flushCntM) : '0;
`else
        expSc = '0;
        expFc = '0;
`endif

        vectors++;
        if (dutCtrl !== exp) begin
            miscompares++;
            $display("[TB] FAIL model_ctrl t=%0t got %b want %b", $time, dutCtrl, exp);
        end
        vectors++;
        if (hif.StallCnt !== expSc) begin
            miscompares++;
            $display("[TB] FAIL model_StallCnt t=%0t got %0d want %0d", $time, hif.StallCnt, expSc);
        end
        vectors++;
        if (hif.FlushCnt !== expFc) begin
            miscompares++;
            $display("[TB] FAIL model_FlushCnt t=%0t got %0d want %0d", $time, hif.FlushCnt, expFc);
        end

        if (!rst_n) begin
            mulLeft   = 0;
            stallCntM = 0;
            flushCntM = 0;
        end else begin
            if (exp[6] && stallCntM < (2**CNT_W - 1)) stallCntM++;
            if (isBranch && flushCntM < (2**CNT_W - 1)) flushCntM++;
            if (!mw) begin
                if (mulLeft > 0)
                    mulLeft--;
                else if (!hif.PCSrcE && hif.MulStartE && MUL_LAT > 1)
                    mulLeft = MUL_LAT - 1;
            end
        end
    end

    // Drive one cycle's worth of inputs, just after the rising edge.
    task automatic applyStimulus(input logic rstN, input logic [AW-1:0] rs1,
                                 input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                                 input logic regWr, input logic lme, input logic pcSrc,
                                 input logic mulStart, input logic memReq,
                                 input logic memReady);
        @(posedge clk);
        #1;
        rst_n         = rstN;
        hif.Rs1D      = rs1;
        hif.Rs2D      = rs2;
        hif.RdE       = rd;
        hif.RegWriteE = regWr;
        hif.LME       = lme;
        hif.PCSrcE    = pcSrc;
        hif.MulStartE = mulStart;
        hif.MemReqM   = memReq;
        hif.MemReadyM = memReady;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Hand-computed expectation for the control bundle, sampled mid-cycle.
    task automatic checkOutput(input string name, input logic [6:0] expCtrl);
        @(negedge clk);
        vectors++;
        if (dutCtrl !== expCtrl) begin
            miscompares++;
            $display("[TB] FAIL %s got %b want %b", name, dutCtrl, expCtrl);
        end
    endtask

    task automatic checkCount(input string name, input logic [CNT_W-1:0] actual,
                              input logic [CNT_W-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        rst_n         = 1'b0;
        hif.Rs1D      = '0;
        hif.Rs2D      = '0;
        hif.RdE       = '0;
        hif.RegWriteE = 1'b0;
        hif.LME       = 1'b0;
        hif.PCSrcE    = 1'b0;
        hif.MulStartE = 1'b0;
        hif.MemReqM   = 1'b0;
        hif.MemReadyM = 1'b1;

        // Reset: only the two flushes are high.
        checkOutput("reset0", 7'b0000110);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset1", 7'b0000110);
        checkCount("reset_StallCnt", hif.StallCnt, 16'd0);
        applyIdle();
        checkOutput("idle", 7'b0000000);

        // T1: load-use on Rs1D, then on Rs2D; each is a single bubble.
        applyStimulus(1'b1, 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("loaduse_rs1", 7'b1100010);
        applyIdle();
        checkOutput("loaduse_clear", 7'b0000000);
        applyStimulus(1'b1, 4'd1, 4'd7, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("loaduse_rs2", 7'b1100010);

        // T2: no dependency through r0, none without RegWriteE, none without LME.
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("loaduse_r0", 7'b0000000);
        applyStimulus(1'b1, 4'd0, 4'd5, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("loaduse_noRegWrite", 7'b0000000);
        applyStimulus(1'b1, 4'd5, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("loaduse_notLoad", 7'b0000000);

        // T3: branch flush alone, with a load-use match, and over MulStartE.
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("branch", 7'b0000110);
        applyStimulus(1'b1, 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("branch_over_loaduse", 7'b0000110);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("branch_over_mul", 7'b0000110);
        applyIdle();
        checkOutput("branch_over_mul_noMul", 7'b0000000);

        // T4: MUL_LAT=4 gives 3 stall cycles and 4 busy cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            checkOutput("mul_stall", 7'b1110001);
        end
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul_last", 7'b0000001);
        applyIdle();
        checkOutput("mul_done", 7'b0000000);

        // A branch seen while in MUL is ignored.
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul2_entry", 7'b1110001);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("mul2_ignoreBranch", 7'b1110001);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul2_stall", 7'b1110001);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul2_last", 7'b0000001);
        applyIdle();
        checkOutput("mul2_done", 7'b0000000);

        // T5: a 5-cycle memory wait during MUL freezes the sequencer.
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul3_entry", 7'b1110001);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul3_stall", 7'b1110001);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput("mul3_memwait", 7'b1111001);
        end
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("mul3_resume", 7'b1110001);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul3_last", 7'b0000001);
        applyIdle();
        checkOutput("mul3_done", 7'b0000000);

        // Memory wait in RUN masks a branch and a load-use; the branch acts on release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput("memwait_run", 7'b1111000);
        end
        applyStimulus(1'b1, 4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("memwait_release_branch", 7'b0000110);
        applyIdle();
        checkOutput("memwait_after", 7'b0000000);

        // T6: reset in the middle of a multiply returns straight to RUN.
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul4_entry", 7'b1110001);
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul4_stall", 7'b1110001);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mul4_reset", 7'b0000110);
        applyIdle();
        checkOutput("mul4_afterReset", 7'b0000000);
        applyIdle();
        checkOutput("mul4_afterReset2", 7'b0000000);

`ifdef HAZ_PERF_CNT_EN
        // A long memory wait drives StallCnt into saturation.
        applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        checkCount("StallCnt_saturated", hif.StallCnt, 16'hFFFF);
        applyIdle();
        checkOutput("sat_idle", 7'b0000000);
        checkCount("StallCnt_held", hif.StallCnt, 16'hFFFF);
`else
        @(negedge clk);
        checkCount("StallCnt_off", hif.StallCnt, 16'd0);
        checkCount("FlushCnt_off", hif.FlushCnt, 16'd0);
`endif

        applyIdle();
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
